// File: rtl/stream_pkg.sv
// Constants and types shared between the stream burst buffer and the SDRAM write controller.
package stream_pkg;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  localparam int DEFAULT_DEPTH     = 512;
  localparam int DEFAULT_AW        = 9;
  localparam int DEFAULT_BURST_LEN = 256;

endpackage

// File: rtl/stream_fifo_ram.sv
// Simple dual-port DEPTH x 32 RAM: synchronous write port, registered read port.
module stream_fifo_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: the array has no reset so it can map onto block RAM; only the output register is reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/stream_burst_buffer.sv
// Buffers generator words in a FIFO and releases them to the SDRAM controller in fixed-length bursts.
module stream_burst_buffer
  import stream_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AW        = DEFAULT_AW,
  parameter int BURST_LEN = DEFAULT_BURST_LEN
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic [31:0]   s32,
  input  logic          n32rdy,
  output logic          burst_req,
  input  logic          burst_ack,
  input  logic          rd,
  output logic [31:0]   dout,
  output logic          dout_vld,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          proto_err,
  input  logic          clr_err
);

  localparam int            BW         = $clog2(BURST_LEN) + 1;
  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   BURST_THR  = (AW+1)'(BURST_LEN);
  localparam logic [AW:0]   LVL_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = (AW)'(1);
  localparam logic [BW-1:0] BEAT_ONE   = (BW)'(1);
  localparam logic [BW-1:0] LAST_BEAT  = (BW)'(BURST_LEN - 1);

  state_t        state, state_next;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   level_q;
  logic [BW-1:0] beat;
  logic          wr_acc, rd_acc, ovf_evt, proto_evt;

  // A full FIFO drops the incoming word even when a read frees a slot in the same cycle.
  assign wr_acc    = n32rdy && (level_q != FULL_LEVEL);
  assign ovf_evt   = n32rdy && (level_q == FULL_LEVEL);
  assign rd_acc    = rd && (state == ST_XFER);
  assign proto_evt = (rd && (state != ST_XFER)) || (burst_ack && (state != ST_REQ));

  assign burst_req = (state == ST_REQ);
  assign level     = level_q;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (level_q >= BURST_THR)              state_next = ST_REQ;
      ST_REQ:  if (burst_ack)                         state_next = ST_XFER;
      ST_XFER: if (rd_acc && (beat == LAST_BEAT))     state_next = ST_IDLE;
      default:                                        state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= ST_IDLE;
      wptr      <= '0;
      rptr      <= '0;
      level_q   <= '0;
      beat      <= '0;
      dout_vld  <= OFF;
      overflow  <= OFF;
      proto_err <= OFF;
    end else begin
      state    <= state_next;
      dout_vld <= rd_acc;
      if (wr_acc) wptr <= wptr + PTR_ONE;
      if (rd_acc) rptr <= rptr + PTR_ONE;
      unique case ({wr_acc, rd_acc})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
      if (state == ST_REQ && burst_ack) beat <= '0;
      else if (rd_acc)                  beat <= beat + BEAT_ONE;
      // A new error event in the same cycle as clr_err keeps the flag set.
      overflow  <= ovf_evt   || (overflow  && !clr_err);
      proto_err <= proto_evt || (proto_err && !clr_err);
    end
  end

  stream_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .n_rst (n_rst),
    .we    (wr_acc),
    .waddr (wptr),
    .wdata (s32),
    .re    (rd_acc),
    .raddr (rptr),
    .rdata (dout)
  );

endmodule

// File: tb/tb_stream_burst_buffer.sv
// Scoreboard bench for stream_burst_buffer: directed stimulus, expected read data queued, monitor compares.
module tb_stream_burst_buffer;
  import stream_pkg::*;

  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int BL    = 256;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [31:0]   s32;
  logic          n32rdy, burst_ack, rd, clr_err;
  logic          burst_req, dout_vld, overflow, proto_err;
  logic [31:0]   dout;
  logic [AW:0]   level;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  int          m_level;
  int          m_beat;
  state_t      m_state;
  bit          m_ovf, m_proto;

  stream_burst_buffer #(.DEPTH(DEPTH), .AW(AW), .BURST_LEN(BL)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .s32       (s32),
    .n32rdy    (n32rdy),
    .burst_req (burst_req),
    .burst_ack (burst_ack),
    .rd        (rd),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .level     (level),
    .overflow  (overflow),
    .proto_err (proto_err),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented read word must match the oldest expected word.
  always @(negedge clk) begin
    if (n_rst && dout_vld) begin
      if (exp_q.size() == 0) begin
        check("dout_vld_unexpected", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("dout", dout, mon_exp);
      end
    end
  end

  task automatic model_clear();
    model_q.delete();
    exp_q.delete();
    m_level = 0;
    m_beat  = 0;
    m_state = ST_IDLE;
    m_ovf   = 1'b0;
    m_proto = 1'b0;
  endtask

  // One clock cycle of stimulus; the bench model predicts acceptance, level, state and flags.
  task automatic step(input bit w, input logic [31:0] d, input bit r, input bit a, input bit c);
    bit wr_ok, rd_ok, ovf_evt, proto_evt;
    int lvl_before;
    n32rdy = w; s32 = d; rd = r; burst_ack = a; clr_err = c;
    lvl_before = m_level;
    wr_ok      = w && (m_level < DEPTH);
    rd_ok      = r && (m_state == ST_XFER);
    ovf_evt    = w && !wr_ok;
    proto_evt  = (r && m_state != ST_XFER) || (a && m_state != ST_REQ);
    if (wr_ok) model_q.push_back(d);
    if (rd_ok) exp_q.push_back(model_q.pop_front());
    m_level = m_level + int'(wr_ok) - int'(rd_ok);
    m_ovf   = ovf_evt || (m_ovf && !c);
    m_proto = proto_evt || (m_proto && !c);
    case (m_state)
      ST_IDLE: if (lvl_before >= BL) m_state = ST_REQ;
      ST_REQ:  if (a) begin m_state = ST_XFER; m_beat = 0; end
      ST_XFER: if (rd_ok) begin
                 if (m_beat == BL - 1) m_state = ST_IDLE;
                 m_beat++;
               end
      default: m_state = ST_IDLE;
    endcase
    @(posedge clk);
    #1;
    n32rdy = 1'b0; rd = 1'b0; burst_ack = 1'b0; clr_err = 1'b0;
    check("level", 32'(level), 32'(m_level));
    check("burst_req", 32'(burst_req), 32'(m_state == ST_REQ));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("proto_err", 32'(proto_err), 32'(m_proto));
  endtask

  task automatic do_reset(input string tag);
    n_rst = 1'b0;
    n32rdy = 1'b0; rd = 1'b0; burst_ack = 1'b0; clr_err = 1'b0; s32 = '0;
    #2;
    check({tag, "_level"},     32'(level),     32'd0);
    check({tag, "_burst_req"}, 32'(burst_req), 32'd0);
    check({tag, "_dout"},      dout,           32'd0);
    check({tag, "_dout_vld"},  32'(dout_vld),  32'd0);
    check({tag, "_overflow"},  32'(overflow),  32'd0);
    check({tag, "_proto_err"}, 32'(proto_err), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  initial begin
    int lvl_hold;
    n_rst = 1'b1;
    n32rdy = 1'b0; rd = 1'b0; burst_ack = 1'b0; clr_err = 1'b0; s32 = '0;
    #3;
    do_reset("reset");

    // Slow fill: one word every 12 cycles until a burst is ready.
    for (int i = 0; i < BL; i++) begin
      step(1'b1, 32'hFAFB_FCFD + 32'(i), 1'b0, 1'b0, 1'b0);
      repeat (11) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    end
    check("burst_req_after_fill", 32'(burst_req), 32'd1);

    // Acknowledge and drain with contiguous reads.
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < BL; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("level_after_drain", 32'(level), 32'd0);
    check("burst_req_after_drain", 32'(burst_req), 32'd0);

    // Fill to full without ack, then one extra word that must be dropped.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h1000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    check("level_full", 32'(level), 32'd512);
    check("overflow_set", 32'(overflow), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("overflow_cleared", 32'(overflow), 32'd0);

    // First half drains, then the FSM re-requests back to back.
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < BL; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("burst_req_back_to_back", 32'(burst_req), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Interleaved writes and gapped reads across the pointer wrap.
    for (int j = 0; j < 2 * BL; j++) begin
      lvl_hold = int'(level);
      step((j % 12) == 0, 32'h2000_0000 + 32'(j), (j % 2) == 0, 1'b0, 1'b0);
      if ((j % 12) == 0) check("level_rd_wr_same_cycle", 32'(level), 32'(lvl_hold));
    end
    check("level_after_interleave", 32'(level), 32'd43);

    // Read strobe while idle is a protocol error with no side effects.
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("proto_rd_idle", 32'(proto_err), 32'd1);
    check("level_rd_idle", 32'(level), 32'd43);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Refill to a burst, then a stray ack during the transfer.
    for (int i = 0; i < BL - 43; i++) step(1'b1, 32'h3000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("proto_ack_xfer", 32'(proto_err), 32'd1);
    check("level_ack_xfer", 32'(level), 32'd256);

    // Asynchronous reset in the middle of a transfer.
    for (int i = 0; i < 100; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    do_reset("midxfer_reset");

    for (int i = 0; i < BL; i++) step(1'b1, 32'h4000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("burst_req_after_refill", 32'(burst_req), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < BL; i++) step(1'b0, '0, (i % 3) != 2, 1'b0, 1'b0);
    while (m_state == ST_XFER) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
